// File: rtl/mvm_param_fifo.sv
// Streaming matrix-vector multiplier y = W*x with one pipelined MAC and an output FIFO.
// Optional build macro MVM_RELU_EN clamps negative results to zero before they enter the FIFO.
module mvm_param_fifo #(
  parameter int WIDTH     = 12,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int OUT_DEPTH = 2,
  localparam int OUT_WIDTH = 2*WIDTH + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [WIDTH-1:0]     input_data,
  input  logic                 new_matrix,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [OUT_WIDTH-1:0] output_data
);

  localparam int MN     = M * N;
  localparam int LD_W   = $clog2(MN);
  localparam int COL_W  = $clog2(N);
  localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1) + 1;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  state_e                     state_q;
  logic                       input_ready_q;
  logic                       w_loaded_q;
  logic [LD_W-1:0]            load_cnt_q;
  logic [ROW_W-1:0]           row_q;
  logic [COL_W-1:0]           col_q;

  logic signed [WIDTH-1:0]    w_mem_q [MN];
  logic signed [WIDTH-1:0]    x_mem_q [N];

  logic                       p1_vld_q, p1_first_q, p1_last_q;
  logic signed [WIDTH-1:0]    p1_a_q, p1_b_q;
  logic                       p2_vld_q, p2_first_q, p2_last_q;
  logic signed [PROD_W-1:0]   p2_prod_q;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic                       acc_done_q;
  logic [CNT_W-1:0]           in_flight_q;

  logic [OUT_WIDTH-1:0]       fifo_mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                       output_valid_q;

  logic                       in_xfer_s, take_w_s, take_x_s;
  logic [LD_W-1:0]            wr_addr_s, w_raddr_s;
  logic                       credit_ok_s, issue_s, start_row_s, last_col_s;
  logic                       push_s, pop_s;
  logic signed [OUT_WIDTH-1:0] prod_ext_s;
  logic [OUT_WIDTH-1:0]       push_data_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign output_data  = fifo_mem_q[rd_ptr_q];

  // Write steering, MAC issue control and FIFO bookkeeping.
  always_comb begin
    in_xfer_s = input_valid && input_ready_q;
    take_w_s  = 1'b0;
    take_x_s  = 1'b0;
    wr_addr_s = load_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wr_addr_s = '0;
        if (new_matrix || !w_loaded_q) begin
          take_w_s = in_xfer_s;
        end else begin
          take_x_s = in_xfer_s;
        end
      end
      ST_LOAD_W: take_w_s = in_xfer_s;
      ST_LOAD_X: take_x_s = in_xfer_s;
      default: begin
        take_w_s = 1'b0;
        take_x_s = 1'b0;
      end
    endcase

    // A new row may start only if its result is guaranteed a FIFO slot.
    credit_ok_s = (fifo_cnt_q + in_flight_q) < CNT_W'(OUT_DEPTH);
    issue_s     = (state_q == ST_COMPUTE) && ((col_q != '0) || credit_ok_s);
    start_row_s = issue_s && (col_q == '0);
    last_col_s  = (col_q == COL_W'(N - 1));
    w_raddr_s   = LD_W'(row_q) * LD_W'(N) + LD_W'(col_q);
    prod_ext_s  = OUT_WIDTH'(p2_prod_q);

    push_s = acc_done_q;
    pop_s  = output_valid_q && output_ready;
`ifdef MVM_RELU_EN
    if (acc_q[OUT_WIDTH-1]) begin
      push_data_s = '0;
    end else begin
      push_data_s = acc_q;
    end
`else
    push_data_s = acc_q;
`endif

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Operand storage, left unreset.
  always_ff @(posedge clk) begin
    if (take_w_s) begin
      w_mem_q[wr_addr_s] <= input_data;
    end
    if (take_x_s) begin
      x_mem_q[wr_addr_s[COL_W-1:0]] <= input_data;
    end
  end

  // Job sequencing FSM with registered input_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      input_ready_q <= 1'b1;
      w_loaded_q    <= 1'b0;
      load_cnt_q    <= '0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_xfer_s) begin
            load_cnt_q <= LD_W'(1);
            state_q    <= take_w_s ? ST_LOAD_W : ST_LOAD_X;
          end
        end
        ST_LOAD_W: begin
          if (in_xfer_s) begin
            if (load_cnt_q == LD_W'(MN - 1)) begin
              w_loaded_q <= 1'b1;
              load_cnt_q <= '0;
              state_q    <= ST_LOAD_X;
            end else begin
              load_cnt_q <= load_cnt_q + LD_W'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (in_xfer_s) begin
            if (load_cnt_q == LD_W'(N - 1)) begin
              load_cnt_q    <= '0;
              row_q         <= '0;
              col_q         <= '0;
              input_ready_q <= 1'b0;
              state_q       <= ST_COMPUTE;
            end else begin
              load_cnt_q <= load_cnt_q + LD_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (issue_s) begin
            if (last_col_s) begin
              col_q <= '0;
              if (row_q == ROW_W'(M - 1)) begin
                row_q   <= '0;
                state_q <= ST_DRAIN;
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (in_flight_q == '0) begin
            input_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          input_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  // MAC pipeline: operand read, product, accumulate; accumulator reloads on column 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_vld_q    <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_a_q      <= '0;
      p1_b_q      <= '0;
      p2_vld_q    <= 1'b0;
      p2_first_q  <= 1'b0;
      p2_last_q   <= 1'b0;
      p2_prod_q   <= '0;
      acc_q       <= '0;
      acc_done_q  <= 1'b0;
      in_flight_q <= '0;
    end else begin
      p1_vld_q   <= issue_s;
      p1_first_q <= start_row_s;
      p1_last_q  <= issue_s && last_col_s;
      if (issue_s) begin
        p1_a_q <= w_mem_q[w_raddr_s];
        p1_b_q <= x_mem_q[col_q];
      end
      p2_vld_q   <= p1_vld_q;
      p2_first_q <= p1_first_q;
      p2_last_q  <= p1_last_q;
      if (p1_vld_q) begin
        p2_prod_q <= PROD_W'(p1_a_q) * PROD_W'(p1_b_q);
      end
      acc_done_q <= p2_vld_q && p2_last_q;
      if (p2_vld_q) begin
        acc_q <= p2_first_q ? prod_ext_s : (acc_q + prod_ext_s);
      end
      if (start_row_s && !push_s) begin
        in_flight_q <= in_flight_q + CNT_W'(1);
      end else if (!start_row_s && push_s) begin
        in_flight_q <= in_flight_q - CNT_W'(1);
      end else begin
        in_flight_q <= in_flight_q;
      end
    end
  end

  // Output FIFO; entries are cleared on reset so output_data reads zero when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      output_valid_q <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= push_data_s;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q     <= fifo_cnt_d;
      output_valid_q <= (fifo_cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_mvm_param_fifo.sv
// Scoreboard bench for mvm_param_fifo: a 4x4 instance and a 3x5 instance share clock, reset and data bus.
module tb_mvm_param_fifo;

  localparam int W   = 12;
  localparam int OW0 = 2*W + 2;
  localparam int OW1 = 2*W + 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid0, in_valid1, in_ready0, in_ready1;
  logic out_valid0, out_valid1, out_ready0, out_ready1;
  logic [W-1:0] in_data;
  logic new_mat;
  logic signed [OW0-1:0] out_data0;
  logic signed [OW1-1:0] out_data1;

  int checks = 0;
  int failures = 0;
  longint exp0[$];
  longint exp1[$];
  int wm[0:19];
  int xv[0:4];
  bit jobs_done;

  always #5 clk = ~clk;

  mvm_param_fifo #(.WIDTH(W), .M(4), .N(4), .OUT_DEPTH(2)) dut0 (
    .clk(clk), .reset(rst), .input_valid(in_valid0), .input_ready(in_ready0),
    .input_data(in_data), .new_matrix(new_mat), .output_valid(out_valid0),
    .output_ready(out_ready0), .output_data(out_data0));

  mvm_param_fifo #(.WIDTH(W), .M(3), .N(5), .OUT_DEPTH(2)) dut1 (
    .clk(clk), .reset(rst), .input_valid(in_valid1), .input_ready(in_ready1),
    .input_data(in_data), .new_matrix(new_mat), .output_valid(out_valid1),
    .output_ready(out_ready1), .output_data(out_data1));

  task automatic tb_check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic send_word(input int sel, input int d, input logic nm, input bit gaps);
    bit acc;
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) tick();
    end
    in_data = W'(d);
    new_mat = nm;
    if (sel == 0) in_valid0 = 1'b1;
    else          in_valid1 = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = (sel == 0) ? in_ready0 : in_ready1;
      tick();
      guard++;
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    tb_check("send_accept", acc, 1);
  endtask

  // Golden model runs when the job is issued; results queue behind any older ones.
  task automatic run_job(input int sel, input int m, input int n, input bit send_w, input logic nm, input bit gaps);
    longint y;
    for (int r = 0; r < m; r++) begin
      y = 0;
      for (int c = 0; c < n; c++) y += longint'(wm[r*n + c]) * longint'(xv[c]);
`ifdef MVM_RELU_EN
      if (y < 0) y = 0;
`endif
      if (sel == 0) exp0.push_back(y);
      else          exp1.push_back(y);
    end
    if (send_w) begin
      for (int k = 0; k < m*n; k++)
        send_word(sel, wm[k], (k == 0) ? nm : 1'($urandom_range(0, 1)), gaps);
    end
    for (int k = 0; k < n; k++)
      send_word(sel, xv[k], (!send_w && k == 0) ? nm : 1'($urandom_range(0, 1)), gaps);
  endtask

  task automatic wait_drain(input int sel);
    int guard = 0;
    while (((sel == 0) ? exp0.size() : exp1.size()) > 0 && guard < 1000) begin
      tick();
      guard++;
    end
    tb_check((sel == 0) ? "drain0" : "drain1", (sel == 0) ? exp0.size() : exp1.size(), 0);
    repeat (5) tick();
  endtask

  always @(negedge clk) begin
    if (out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
      tb_check("pop_avail0", exp0.size() > 0, 1);
      if (exp0.size() > 0) tb_check("y_dut0", out_data0, exp0.pop_front());
    end
    if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
      tb_check("pop_avail1", exp1.size() > 0, 1);
      if (exp1.size() > 0) tb_check("y_dut1", out_data1, exp1.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    int changes;
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    in_data = '0; new_mat = 1'b0;
    jobs_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    tb_check("rst_out_valid0", out_valid0, 0);
    tb_check("rst_out_valid1", out_valid1, 0);
    tb_check("rst_in_ready0", in_ready0, 1);
    tb_check("rst_in_ready1", in_ready1, 1);
    tb_check("rst_out_data0", out_data0, 0);
    tick();

    // Identity matrix plus latency from COMPUTE entry.
    for (int k = 0; k < 16; k++) wm[k] = ((k / 4) == (k % 4)) ? 1 : 0;
    for (int c = 0; c < 4; c++) xv[c] = c + 1;
    run_job(0, 4, 4, 1'b1, 1'b1, 1'b0);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    tb_check("latency", lat, 7);
    wait_drain(0);

    // Matrix reuse, vector only.
    xv[0] = -5; xv[1] = 0; xv[2] = 7; xv[3] = 100;
    run_job(0, 4, 4, 1'b0, 1'b0, 1'b0);
    wait_drain(0);

    // Operand extremes.
    for (int k = 0; k < 16; k++) wm[k] = -2048;
    for (int c = 0; c < 4; c++) xv[c] = -2048;
    run_job(0, 4, 4, 1'b1, 1'b1, 1'b0);
    wait_drain(0);
    for (int c = 0; c < 4; c++) xv[c] = 2047;
    run_job(0, 4, 4, 1'b0, 1'b0, 1'b0);
    wait_drain(0);

    // Backpressure: consumer stalled for 40 cycles.
    for (int k = 0; k < 16; k++) wm[k] = rnd_op();
    for (int c = 0; c < 4; c++) xv[c] = rnd_op();
    out_ready0 = 1'b0;
    run_job(0, 4, 4, 1'b1, 1'b1, 1'b0);
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid0 && out_data0 !== OW0'(exp0[0])) changes++;
      tick();
    end
    @(negedge clk);
    tb_check("bp_valid", out_valid0, 1);
    tb_check("bp_head", out_data0, exp0[0]);
    tb_check("bp_hold", changes, 0);
    tb_check("bp_stall_ready", in_ready0, 0);
    tb_check("bp_queue", exp0.size(), 4);
    tick();
    out_ready0 = 1'b1;
    wait_drain(0);

    // Overlapped jobs with input gaps and a slow consumer.
    for (int k = 0; k < 16; k++) wm[k] = rnd_op();
    for (int c = 0; c < 4; c++) xv[c] = rnd_op();
    jobs_done = 1'b0;
    fork
      begin
        run_job(0, 4, 4, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) xv[c] = rnd_op();
        run_job(0, 4, 4, 1'b0, 1'b0, 1'b1);
        jobs_done = 1'b1;
      end
      begin
        int g = 0;
        while ((!jobs_done || exp0.size() > 0) && g < 4000) begin
          out_ready0 = ($urandom_range(0, 3) == 0);
          tick();
          g++;
        end
        out_ready0 = 1'b1;
      end
    join
    wait_drain(0);

    // Non-square instance, normal job.
    for (int k = 0; k < 15; k++) wm[k] = rnd_op();
    for (int c = 0; c < 5; c++) xv[c] = rnd_op();
    run_job(1, 3, 5, 1'b1, 1'b1, 1'b1);
    wait_drain(1);

    // Reset in the middle of COMPUTE.
    out_ready1 = 1'b0;
    for (int k = 0; k < 15; k++) wm[k] = rnd_op();
    for (int c = 0; c < 5; c++) xv[c] = rnd_op();
    run_job(1, 3, 5, 1'b1, 1'b1, 1'b0);
    repeat (9) tick();
    @(negedge clk);
    tb_check("pre_rst_valid", out_valid1, 1);
    tb_check("pre_rst_ready", in_ready1, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp1.delete();
    @(negedge clk);
    tb_check("post_rst_valid", out_valid1, 0);
    tb_check("post_rst_ready", in_ready1, 1);
    tb_check("post_rst_data", out_data1, 0);
    tick();
    out_ready1 = 1'b1;
    for (int k = 0; k < 15; k++) wm[k] = rnd_op();
    for (int c = 0; c < 5; c++) xv[c] = rnd_op();
    run_job(1, 3, 5, 1'b1, 1'b0, 1'b0);
    wait_drain(1);
    for (int c = 0; c < 5; c++) xv[c] = rnd_op();
    run_job(1, 3, 5, 1'b0, 1'b0, 1'b1);
    wait_drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
